// File: rtl/idft_wb_stream_bridge.sv
// idft_wb_stream_bridge: Wishbone B3 classic slave that buffers bus-written
// samples in an input FIFO, streams one frame into an IDFT core on command,
// and collects the results in an output FIFO drained by bus reads.
//   clk, rst_sys_n       : clock, async active-low reset
//   wb_*                 : Wishbone classic slave (registered ack/err, rty = 0)
//   core_in_*            : sample stream to the core (valid/ready/last)
//   core_out_*           : result stream from the core (valid/ready/last)
//   core_clr             : one-cycle core flush pulse on soft clear
//   irq                  : completion interrupt
// Optional build macro IDFT_BRIDGE_IRQ_EN builds the completion interrupt;
// without it irq is tied low.
module idft_wb_stream_bridge #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned FRAME_LEN  = 64
) (
  input  logic                  clk,
  input  logic                  rst_sys_n,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic [2:0]            wb_cti_i,
  input  logic [1:0]            wb_bte_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  output logic [DATA_WIDTH-1:0] core_in_data,
  output logic                  core_in_valid,
  output logic                  core_in_last,
  input  logic                  core_in_ready,
  input  logic [DATA_WIDTH-1:0] core_out_data,
  input  logic                  core_out_valid,
  input  logic                  core_out_last,
  output logic                  core_out_ready,
  output logic                  core_clr,
  output logic                  irq
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIN    = 2'd2;
  localparam logic [1:0] REG_DOUT   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;
  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] in_mem  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] out_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] in_wr_q, in_rd_q, out_wr_q, out_rd_q;
  logic [CNT_W-1:0] in_cnt_q, out_cnt_q, smp_cnt_q, res_cnt_q;
  logic done_q, start_err_q, frame_err_q, irq_en_q, busy_c;

  logic unused_inputs;
  assign unused_inputs = ^{wb_cti_i, wb_bte_i, wb_adr_i[ADDR_WIDTH-1:4], wb_adr_i[1:0]};
  assign wb_rty_o = 1'b0;

  logic [1:0] reg_sel;
  logic bus_req, bus_err_c, bus_ok, ctrl_wr, din_push, dout_pop;
  logic soft_clr, start_req, start_go, start_bad, clr_sticky;
  logic in_empty, in_full, out_empty, out_full, in_pop, out_push;
  logic in_last_xfer, res_is_last, out_last_xfer;
  logic [DATA_WIDTH-1:0] rd_data_c;

  assign in_empty  = (in_cnt_q == '0);
  assign in_full   = (in_cnt_q == CNT_W'(FIFO_DEPTH));
  assign out_empty = (out_cnt_q == '0);
  assign out_full  = (out_cnt_q == CNT_W'(FIFO_DEPTH));

  // A new request is only seen once the previous termination has dropped.
  assign bus_req = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign reg_sel = wb_adr_i[3:2];

  // Illegal accesses terminate with err and have no side effect.
  always_comb begin
    bus_err_c = 1'b0;
    unique case (reg_sel)
      REG_CTRL:   bus_err_c = 1'b0;
      REG_STATUS: bus_err_c = wb_we_i;
      REG_DIN:    bus_err_c = ~wb_we_i | (wb_sel_i != 4'hF) | in_full;
      REG_DOUT:   bus_err_c = wb_we_i | out_empty;
    endcase
  end

  assign bus_ok     = bus_req & ~bus_err_c;
  assign ctrl_wr    = bus_ok & wb_we_i & (reg_sel == REG_CTRL);
  assign din_push   = bus_ok & wb_we_i & (reg_sel == REG_DIN);
  assign dout_pop   = bus_ok & ~wb_we_i & (reg_sel == REG_DOUT);
  assign soft_clr   = ctrl_wr & wb_dat_i[1];
  assign clr_sticky = ctrl_wr & wb_dat_i[2];
  assign start_req  = ctrl_wr & wb_dat_i[0] & ~wb_dat_i[1];
  assign start_go   = start_req & (state_q == S_IDLE) & (in_cnt_q >= CNT_W'(FRAME_LEN));
  assign start_bad  = start_req & ~start_go;

  assign in_pop        = core_in_valid & core_in_ready;
  assign in_last_xfer  = in_pop & core_in_last;
  assign out_push      = core_out_valid & core_out_ready;
  assign res_is_last   = (res_cnt_q == CNT_W'(FRAME_LEN - 1));
  assign out_last_xfer = out_push & res_is_last;

  // Read data mux.
  always_comb begin
    rd_data_c = '0;
    unique case (reg_sel)
      REG_CTRL:   rd_data_c = DATA_WIDTH'({irq_en_q, 3'b000});
      REG_STATUS: rd_data_c = DATA_WIDTH'({8'h00, 8'(out_cnt_q), 8'(in_cnt_q), 4'h0,
                                           frame_err_q, start_err_q, done_q, busy_c});
      REG_DIN:    rd_data_c = '0;
      REG_DOUT:   rd_data_c = out_mem[out_rd_q];
    endcase
  end

  // Registered bus termination.
  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= bus_ok;
      wb_err_o <= bus_req & bus_err_c;
      wb_dat_o <= (bus_ok & ~wb_we_i) ? rd_data_c : '0;
    end
  end

  // FIFO storage (no reset needed; pointers define validity).
  always_ff @(posedge clk) begin
    if (din_push) in_mem[in_wr_q] <= wb_dat_i;
    if (out_push) out_mem[out_wr_q] <= core_out_data;
  end

  // FIFO pointers and occupancy; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      in_wr_q <= '0; in_rd_q <= '0; in_cnt_q <= '0;
      out_wr_q <= '0; out_rd_q <= '0; out_cnt_q <= '0;
    end else if (soft_clr) begin
      in_wr_q <= '0; in_rd_q <= '0; in_cnt_q <= '0;
      out_wr_q <= '0; out_rd_q <= '0; out_cnt_q <= '0;
    end else begin
      if (din_push) in_wr_q <= in_wr_q + PTR_W'(1);
      if (in_pop)   in_rd_q <= in_rd_q + PTR_W'(1);
      in_cnt_q <= in_cnt_q + CNT_W'(din_push) - CNT_W'(in_pop);
      if (out_push) out_wr_q <= out_wr_q + PTR_W'(1);
      if (dout_pop) out_rd_q <= out_rd_q + PTR_W'(1);
      out_cnt_q <= out_cnt_q + CNT_W'(out_push) - CNT_W'(dout_pop);
    end
  end

  // Frame counters.
  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      smp_cnt_q <= '0;
      res_cnt_q <= '0;
    end else if (soft_clr || start_go) begin
      smp_cnt_q <= '0;
      res_cnt_q <= '0;
    end else begin
      if (in_pop)   smp_cnt_q <= smp_cnt_q + CNT_W'(1);
      if (out_push) res_cnt_q <= res_cnt_q + CNT_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    if (soft_clr) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:   if (start_go) state_d = S_STREAM;
        S_STREAM: if (in_last_xfer) state_d = S_DRAIN;
        S_DRAIN:  if (out_last_xfer) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs; all derived from registered state and occupancy.
  always_comb begin
    busy_c         = 1'b0;
    core_in_valid  = 1'b0;
    core_in_last   = 1'b0;
    core_out_ready = 1'b0;
    busy_c         = (state_q != S_IDLE);
    core_in_valid  = (state_q == S_STREAM) & ~in_empty;
    core_in_last   = core_in_valid & (smp_cnt_q == CNT_W'(FRAME_LEN - 1));
    core_out_ready = (state_q == S_DRAIN) & ~out_full;
  end

  assign core_in_data = in_mem[in_rd_q];

  // Status, sticky errors, control bits; later assignments take priority.
  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
      frame_err_q <= 1'b0;
      irq_en_q    <= 1'b0;
      core_clr    <= 1'b0;
    end else begin
      core_clr <= soft_clr;
      if (ctrl_wr) irq_en_q <= wb_dat_i[3];
      if (clr_sticky) begin
        done_q      <= 1'b0;
        start_err_q <= 1'b0;
        frame_err_q <= 1'b0;
      end
      if (start_bad) start_err_q <= 1'b1;
      if (start_go)  done_q <= 1'b0;
      if (out_push && !soft_clr && (core_out_last != res_is_last)) frame_err_q <= 1'b1;
      if (out_last_xfer && !soft_clr) done_q <= 1'b1;
      if (soft_clr) done_q <= 1'b0;
    end
  end

`ifdef IDFT_BRIDGE_IRQ_EN
  // Interrupt follows done & enable one cycle later.
  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) irq <= 1'b0;
    else            irq <= done_q & irq_en_q;
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_idft_wb_stream_bridge.sv
// Scoreboard bench for idft_wb_stream_bridge: bus responses and core-side
// samples are queued as stimulus is issued and checked by monitor processes.
module tb_idft_wb_stream_bridge;
  logic        clk = 1'b0;
  logic        rst_sys_n = 1'b0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
  logic [2:0]  wb_cti_i = '0;
  logic [1:0]  wb_bte_i = '0;
  logic [31:0] wb_dat_o, core_in_data;
  logic        wb_ack_o, wb_err_o, wb_rty_o, core_in_valid, core_in_last;
  logic        core_in_ready = 1'b0;
  logic [31:0] core_out_data = '0;
  logic        core_out_valid = 1'b0, core_out_last = 1'b0;
  logic        core_out_ready, core_clr, irq;

  idft_wb_stream_bridge dut (
    .clk(clk), .rst_sys_n(rst_sys_n),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
    .core_in_data(core_in_data), .core_in_valid(core_in_valid), .core_in_last(core_in_last),
    .core_in_ready(core_in_ready), .core_out_data(core_out_data),
    .core_out_valid(core_out_valid), .core_out_last(core_out_last),
    .core_out_ready(core_out_ready), .core_clr(core_clr), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic err; logic [31:0] dat; logic chk_dat; logic chk; } bus_exp_t;
  typedef struct packed { logic [31:0] dat; logic last; } in_exp_t;
  typedef struct packed { logic [31:0] dat; int due; } pipe_t;

  bus_exp_t bus_q[$];
  in_exp_t  in_exp[$];
  pipe_t    pipe[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, clr_cycles = 0;
  int rdy_mode = 0;
  logic [31:0] last_dat = 32'd63, stall_dat = 32'hFFFF_FFFF;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Bus response monitor.
  bus_exp_t mon_e;
  always @(posedge clk) begin
    if (wb_ack_o | wb_err_o) begin
      if (bus_q.size() == 0) check("bus_unexpected_term", 32'd1, 32'd0);
      else begin
        mon_e = bus_q.pop_front();
        if (mon_e.chk) begin
          check("bus_err", 32'(wb_err_o), 32'(mon_e.err));
          if (mon_e.chk_dat) check("bus_rdata", wb_dat_o, mon_e.dat);
        end
      end
    end
  end

  // Core-side monitor and echo model bookkeeping.
  in_exp_t ie;
  pipe_t   pe;
  always @(posedge clk) begin
    if (core_out_valid & core_out_ready) pipe.delete(0);
    if (core_in_valid & core_in_ready) begin
      if (in_exp.size() == 0) check("core_in_unexpected", 32'd1, 32'd0);
      else begin
        ie = in_exp.pop_front();
        check("core_in_data", core_in_data, ie.dat);
        check("core_in_last", 32'(core_in_last), 32'(ie.last));
      end
      pe.dat = core_in_data;
      pe.due = cyc + 2;
      pipe.push_back(pe);
    end
    if (core_clr) begin
      pipe.delete();
      clr_cycles++;
    end
    cyc++;
  end

  // Core model drive: echo after latency, ready pattern per mode.
  always @(negedge clk) begin
    case (rdy_mode)
      0:       core_in_ready = 1'b1;
      1:       core_in_ready = ~core_in_ready;
      default: core_in_ready = (core_in_data != stall_dat);
    endcase
    if (pipe.size() > 0 && pipe[0].due <= cyc) begin
      core_out_valid = 1'b1;
      core_out_data  = pipe[0].dat;
      core_out_last  = (pipe[0].dat == last_dat);
    end else begin
      core_out_valid = 1'b0;
      core_out_data  = '0;
      core_out_last  = 1'b0;
    end
  end

  task automatic bus(input logic we, input logic [1:0] rg, input logic [31:0] wdat,
                     input logic [3:0] sel, input logic chk, input logic exp_err,
                     input logic [31:0] exp_dat, output logic [31:0] rdat);
    bus_exp_t e;
    int n;
    e.err = exp_err; e.dat = exp_dat; e.chk_dat = ~we; e.chk = chk;
    bus_q.push_back(e);
    @(negedge clk);
    wb_adr_i = {28'h0, rg, 2'b00}; wb_dat_i = wdat; wb_sel_i = sel; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(wb_ack_o | wb_err_o) && n < 20);
    rdat = wb_dat_o;
    if (!(wb_ack_o | wb_err_o)) begin
      check("bus_timeout", 32'd0, 32'd1);
      bus_q.delete(bus_q.size() - 1);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wr(input logic [1:0] rg, input logic [31:0] d, input logic exp_err);
    logic [31:0] x;
    bus(1'b1, rg, d, 4'hF, 1'b1, exp_err, 32'h0, x);
  endtask
  task automatic rd(input logic [1:0] rg, input logic exp_err, input logic [31:0] exp_d);
    logic [31:0] x;
    bus(1'b0, rg, 32'h0, 4'hF, 1'b1, exp_err, exp_d, x);
  endtask
  task automatic rd_nc(input logic [1:0] rg, output logic [31:0] d);
    bus(1'b0, rg, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, d);
  endtask

  task automatic wait_done();
    logic [31:0] s;
    int k;
    s = '0; k = 0;
    while (!s[1] && k < 150) begin rd_nc(2'd1, s); k++; end
    check("done_reached", 32'(s[1]), 32'd1);
  endtask

  task automatic load_frame(input logic [31:0] base, input int n_exp);
    in_exp_t t;
    for (int i = 0; i < 64; i++) begin
      if (i < n_exp) begin
        t.dat = base + 32'(i); t.last = (i == 63);
        in_exp.push_back(t);
      end
      wr(2'd2, base + 32'(i), 1'b0);
    end
  endtask

  initial begin
    logic [31:0] x;
    int k;
    repeat (3) @(negedge clk);
    rst_sys_n = 1'b1;
    @(negedge clk);
    check("reset_outputs", {23'h0, wb_ack_o, wb_err_o, wb_rty_o, core_in_valid, core_in_last,
                            core_out_ready, core_clr, irq, |wb_dat_o}, 32'h0);

    // Reset state and illegal accesses.
    rd(2'd1, 1'b0, 32'h0000_0000);
    rd(2'd3, 1'b1, 32'h0000_0000);
    wr(2'd1, 32'h1, 1'b1);
    wr(2'd3, 32'h1, 1'b1);
    rd(2'd2, 1'b1, 32'h0);
    bus(1'b1, 2'd2, 32'h55, 4'h3, 1'b1, 1'b1, 32'h0, x);
    rd(2'd1, 1'b0, 32'h0000_0000);

    // Full frame with plain echo; FIFO-full write errs.
    rdy_mode = 0; last_dat = 32'd63;
    load_frame(32'd0, 64);
    wr(2'd2, 32'hDEAD, 1'b1);
    wr(2'd0, 32'h1, 1'b0);
    wait_done();
    rd(2'd1, 1'b0, 32'h0040_0002);
    check("frame1_all_streamed", 32'(in_exp.size()), 32'd0);
    for (int i = 0; i < 64; i++) rd(2'd3, 1'b0, 32'(i));
    rd(2'd3, 1'b1, 32'h0);

    // Start with too few samples.
    for (int i = 0; i < 10; i++) wr(2'd2, 32'd500 + 32'(i), 1'b0);
    wr(2'd0, 32'h1, 1'b0);
    repeat (4) @(negedge clk);
    rd(2'd1, 1'b0, 32'h0000_0A06);
    wr(2'd0, 32'h4, 1'b0);
    rd(2'd1, 1'b0, 32'h0000_0A00);
    wr(2'd0, 32'h2, 1'b0);
    rd(2'd1, 1'b0, 32'h0000_0000);

    // Toggling ready, core marks last early -> frame_err.
    rdy_mode = 1; last_dat = 32'd162;
    load_frame(32'd100, 64);
    wr(2'd0, 32'h1, 1'b0);
    wait_done();
    rd(2'd1, 1'b0, 32'h0040_000A);
    for (int i = 0; i < 64; i++) rd(2'd3, 1'b0, 32'd100 + 32'(i));
    wr(2'd0, 32'h4, 1'b0);
    rd(2'd1, 1'b0, 32'h0000_0000);

    // Soft clear mid-stream at sample 20.
    rdy_mode = 2; stall_dat = 32'd220; last_dat = 32'd263;
    load_frame(32'd200, 20);
    wr(2'd0, 32'h1, 1'b0);
    k = 0;
    while (!(core_in_valid && core_in_data == 32'd220) && k < 300) begin @(negedge clk); k++; end
    check("stall_at_sample20", 32'(core_in_valid && core_in_data == 32'd220), 32'd1);
    clr_cycles = 0;
    wr(2'd0, 32'h2, 1'b0);
    check("clr_in_valid_low", 32'(core_in_valid), 32'd0);
    check("clr_out_ready_low", 32'(core_out_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("core_clr_pulse_cycles", 32'(clr_cycles), 32'd1);
    rd(2'd1, 1'b0, 32'h0000_0000);
    check("clr_consumed_20", 32'(in_exp.size()), 32'd0);

    // Interrupt enable readback and interrupt behaviour.
    rdy_mode = 0;
    wr(2'd0, 32'h8, 1'b0);
    rd(2'd0, 1'b0, 32'h0000_0008);
    check("irq_low_before_done", 32'(irq), 32'd0);
`ifdef IDFT_BRIDGE_IRQ_EN
    last_dat = 32'd363;
    load_frame(32'd300, 64);
    wr(2'd0, 32'h9, 1'b0);
    wait_done();
    @(negedge clk);
    check("irq_high_after_done", 32'(irq), 32'd1);
    wr(2'd0, 32'hC, 1'b0);
    @(negedge clk);
    check("irq_low_after_clear", 32'(irq), 32'd0);
`else
    repeat (4) @(negedge clk);
    check("irq_tied_low", 32'(irq), 32'd0);
`endif

    repeat (5) @(negedge clk);
    check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/idft_wb_stream_bridge.md
Name: idft_wb_stream_bridge

Overview:
Wishbone B3 classic slave that sits on bus slave port S1 of the IDFT tile, between the bus and a streaming IDFT core. It buffers input samples written over the bus in an input FIFO and streams exactly one frame into the core on command. It then collects the transformed frame into an output FIFO that software drains by bus reads. Status, sticky errors and an optional completion interrupt are exposed through a 4-word register map.

Parameters:
DATA_WIDTH, 32, bus and sample word width (must be 32)
ADDR_WIDTH, 32, bus address width
FIFO_DEPTH, 64, entries per FIFO (power of two, at least FRAME_LEN)
FRAME_LEN, 64, samples per IDFT frame (2..FIFO_DEPTH)

Ports:
clk  in  1  system clock; all logic on rising edge
rst_sys_n  in  1  asynchronous active-low reset
wb_adr_i  in  ADDR_WIDTH  address; only [3:2] decoded
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte selects
wb_we_i  in  1  write enable
wb_cyc_i  in  1  cycle
wb_stb_i  in  1  strobe
wb_cti_i  in  3  ignored; classic cycles only
wb_bte_i  in  2  ignored
wb_dat_o  out  32  read data
wb_ack_o  out  1  normal termination
wb_err_o  out  1  error termination
wb_rty_o  out  1  constant 0
core_in_data  out  32  sample to core
core_in_valid  out  1  sample valid
core_in_last  out  1  last sample of frame
core_in_ready  in  1  core accepts
core_out_data  in  32  result from core
core_out_valid  in  1  result valid
core_out_last  in  1  core marks last result
core_out_ready  out  1  bridge accepts
core_clr  out  1  one-cycle core flush pulse
irq  out  1  completion interrupt (see Optional Feature)

Behaviour:
- Reset: all outputs 0, both FIFOs empty, FSM in IDLE, sticky bits 0, counters 0.
- Bus timing: termination is registered. ack or err is asserted one cycle after cyc&stb is seen, for exactly one cycle, and is then low for at least one cycle. Read data is valid with ack. Side effects occur on the termination cycle only.
- Register map, selected by adr[3:2]:
  - 0 CTRL (W): bit0 start, bit1 soft clear, bit2 clear sticky bits, bit3 irq_enable (stored). Reads return {28'b0, irq_enable, 3'b0}.
  - 1 STATUS (R): bit0 busy, bit1 done, bit2 start_err, bit3 frame_err, [15:8] input FIFO count, [23:16] output FIFO count.
  - 2 DATA_IN (W): pushes one word.
  - 3 DATA_OUT (R): pops one word.
- Error terminations (err instead of ack, no side effect):
  - write to STATUS or DATA_OUT
  - read of DATA_IN
  - DATA_IN write with wb_sel_i != 4'hF
  - DATA_IN write while the input FIFO is full
  - DATA_OUT read while the output FIFO is empty; wb_dat_o is 0 in this case
- FSM IDLE: on start, if input count >= FRAME_LEN, go to STREAM, clear done and the sample counter. Otherwise stay in IDLE and set start_err. Start while not in IDLE is ignored and sets start_err.
- FSM STREAM:
  - core_in_valid equals input FIFO not empty; data comes from the FIFO head (first-word fall-through).
  - A transfer happens when valid and ready are both high. The counter increments per transfer.
  - core_in_last is high with sample FRAME_LEN-1.
  - After that transfer, core_in_valid drops the next cycle and the FSM goes to DRAIN.
- FSM DRAIN:
  - core_out_ready equals output FIFO not full.
  - Each accepted result is pushed; the output counter increments.
  - On the FRAME_LEN-th result, go to IDLE and set done.
  - If core_out_last disagrees with result index FRAME_LEN-1, set frame_err; termination still follows the counter.
- busy = state != IDLE.
- Simultaneous events:
  - Bus push and core pop on the input FIFO in the same cycle are both performed; the count is unchanged.
  - The same applies to core push and bus pop on the output FIFO.
- Soft clear (any state):
  - Both FIFOs are flushed and the FSM goes to IDLE.
  - core_clr pulses for 1 cycle; core_in_valid and core_out_ready are 0 from the next cycle.
  - done is cleared.
  - Start and soft clear written together: soft clear wins.
- Asynchronous reset mid-frame aborts immediately to the reset state.

Optional Feature:
IDFT_BRIDGE_IRQ_EN.
- Defined: irq is registered and equals done & irq_enable. It clears when done is cleared (bit2, soft clear, or next start).
- Undefined: irq is tied 0, irq_enable still reads back, and no interrupt logic is built.

Test Plan:
- Reset, then read STATUS -> ack, data 0x00000000; read DATA_OUT -> err, data 0.
- Write 64 words 0..63 to DATA_IN, then CTRL=1; core model echoes with 2-cycle latency. Expected: 64 in-transfers, core_in_last only on sample 63, done=1; 64 DATA_OUT reads return 0..63, then the next read errs.
- Write 10 words, then CTRL=1 -> STATUS start_err=1, busy=0, no core_in_valid. Then CTRL=4 -> start_err=0.
- Core model toggles core_in_ready every cycle and asserts core_out_last on result 62 -> frame completes after 64 results and frame_err=1.
- During STREAM at sample 20, write CTRL=2 -> core_clr one-cycle pulse, FIFO counts 0, busy=0 next cycle.
- With IDFT_BRIDGE_IRQ_EN and CTRL=8 before start -> irq rises the cycle after done sets; CTRL=4 drops irq.
